// File: rtl/mem_client.sv
// rtl/mem_client.sv - cache-line client that serialises line reads/writes onto a word-wide memory controller bus.
// Optional build macro MEM_CLIENT_WORD_CHECK_EN enables the sticky proto_err word-count/ordering check.
module mem_client #(
    parameter int WORD_SIZE     = 32,
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDR_BITCOUNT-1:0] req_addr,
    input  logic [CL_SIZE_WIDTH-1:0] req_wdata,
    output logic                     resp_valid,
    output logic                     resp_we,
    output logic [CL_SIZE_WIDTH-1:0] resp_rdata,
    output logic [1:0]               mc_op,
    output logic [ADDR_BITCOUNT-1:0] mc_addr,
    output logic [WORD_SIZE-1:0]     mc_wdata,
    input  logic [WORD_SIZE-1:0]     mc_rdata,
    input  logic                     mc_rd_valid,
    input  logic                     mc_ready,
    input  logic                     mc_tx_done,
    output logic                     proto_err
);
    localparam int N     = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_IDLE     = 3'd1;
    localparam logic [2:0] S_WR_ISSUE = 3'd2;
    localparam logic [2:0] S_WR_SEND  = 3'd3;
    localparam logic [2:0] S_WR_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_WAIT  = 3'd5;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b11;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    logic [2:0]               state_q, state_d;
    logic [1:0]               op_q, op_d;
    logic [ADDR_BITCOUNT-1:0] addr_q, addr_d;
    logic                     we_q, we_d;
    logic [CL_SIZE_WIDTH-1:0] wdata_q, wdata_d;
    logic [CL_SIZE_WIDTH-1:0] line_q, line_d;
    logic [CL_SIZE_WIDTH-1:0] rdata_q, rdata_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     rv_q, rv_d;
    logic                     rwe_q, rwe_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        line_d  = line_q;
        rdata_d = rdata_q;
        idx_d   = idx_q;
        rv_d    = 1'b0;
        rwe_d   = rwe_q;
        case (state_q)
            S_INIT: begin
                if (mc_ready) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (req_valid) begin
                    state_d = req_we ? S_WR_ISSUE : S_RD_WAIT;
                    op_d    = req_we ? OP_WRITE : OP_READ;
                    addr_d  = req_addr;
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                end
            end
            S_WR_ISSUE: begin
                state_d = S_WR_SEND;
            end
            S_WR_SEND: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_WR_WAIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WR_WAIT: begin
                if (mc_tx_done) begin
                    state_d = S_IDLE;
                    op_d    = OP_IDLE;
                    rv_d    = 1'b1;
                    rwe_d   = we_q;
                end
            end
            S_RD_WAIT: begin
                if (mc_rd_valid) begin
                    line_d[int'(idx_q)*WORD_SIZE +: WORD_SIZE] = mc_rdata;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
                // The done cycle carries the final word, so publish the updated line.
                if (mc_tx_done) begin
                    rdata_d = line_d;
                    state_d = S_IDLE;
                    op_d    = OP_IDLE;
                    rv_d    = 1'b1;
                    rwe_d   = we_q;
                end
            end
            default: begin
                state_d = S_INIT;
                op_d    = OP_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            op_q    <= OP_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            idx_q   <= '0;
            rv_q    <= 1'b0;
            rwe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
            idx_q   <= idx_d;
            rv_q    <= rv_d;
            rwe_q   <= rwe_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = rv_q;
    assign resp_we    = rwe_q;
    assign resp_rdata = rdata_q;
    assign mc_op      = op_q;
    assign mc_addr    = addr_q;
    assign mc_wdata   = ((state_q == S_WR_ISSUE) || (state_q == S_WR_SEND))
                        ? wdata_q[int'(idx_q)*WORD_SIZE +: WORD_SIZE] : '0;

`ifdef MEM_CLIENT_WORD_CHECK_EN
    logic [IDX_W:0] cnt_q, cnt_d;
    logic [IDX_W:0] rd_total;
    logic           perr_q, perr_d;

    always_comb begin
        cnt_d    = cnt_q;
        perr_d   = perr_q;
        rd_total = cnt_q + {{IDX_W{1'b0}}, mc_rd_valid};
        case (state_q)
            S_IDLE: cnt_d = '0;
            S_RD_WAIT: begin
                // Saturating count keeps overlong reads from aliasing back to N.
                if (mc_rd_valid && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                if (mc_tx_done && (rd_total != (IDX_W+1)'(N))) perr_d = 1'b1;
            end
            S_WR_ISSUE, S_WR_SEND: begin
                if (mc_tx_done) perr_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            perr_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            perr_q <= perr_d;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_client.sv
// tb/tb_mem_client.sv - self-checking bench for mem_client with a transaction-level expectation model.
module tb_mem_client;
    localparam int W  = 32;
    localparam int CL = 512;
    localparam int A  = 64;
    localparam int N  = 16;

`ifdef MEM_CLIENT_WORD_CHECK_EN
    localparam logic SHORT_PERR = 1'b1;
`else
    localparam logic SHORT_PERR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, req_valid, req_ready, req_we;
    logic [A-1:0]  req_addr;
    logic [CL-1:0] req_wdata;
    logic          resp_valid, resp_we;
    logic [CL-1:0] resp_rdata;
    logic [1:0]    mc_op;
    logic [A-1:0]  mc_addr;
    logic [W-1:0]  mc_wdata, mc_rdata;
    logic          mc_rd_valid, mc_ready, mc_tx_done, proto_err;

    mem_client #(.WORD_SIZE(W), .CL_SIZE_WIDTH(CL), .ADDR_BITCOUNT(A)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_we(resp_we), .resp_rdata(resp_rdata),
        .mc_op(mc_op), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
        .mc_rdata(mc_rdata), .mc_rd_valid(mc_rd_valid),
        .mc_ready(mc_ready), .mc_tx_done(mc_tx_done), .proto_err(proto_err)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_rv  = 0;
    int rv_before;

    logic          chk_en = 1'b0;
    logic          e_ready, e_rv, e_rwe, e_wd_chk, e_addr_chk, e_perr;
    logic          e_in_send = 1'b0;
    logic [1:0]    e_op;
    logic [W-1:0]  e_wdata;
    logic [A-1:0]  e_addr;
    logic [W-1:0]  e_line [N];
    logic          e_ok   [N];
    logic [W-1:0]  q_wd [$];
    logic [CL-1:0] ev, mv;

    task automatic chk(input string nm, input logic [CL-1:0] act, input logic [CL-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", CL'(req_ready), CL'(e_ready));
            chk("mc_op", CL'(mc_op), CL'(e_op));
            chk("resp_valid", CL'(resp_valid), CL'(e_rv));
            chk("proto_err", CL'(proto_err), CL'(e_perr));
            if (e_rv) chk("resp_we", CL'(resp_we), CL'(e_rwe));
            if (e_wd_chk) chk("mc_wdata", CL'(mc_wdata), CL'(e_wdata));
            if (e_addr_chk) chk("mc_addr", CL'(mc_addr), CL'(e_addr));
            ev = '0;
            mv = '0;
            for (int k = 0; k < N; k++) begin
                ev[k*W +: W] = e_line[k];
                if (e_ok[k]) mv[k*W +: W] = '1;
            end
            chk("resp_rdata", resp_rdata & mv, ev & mv);
            if (resp_valid) n_rv++;
            if (e_in_send) q_wd.push_back(mc_wdata);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        req_valid = 1'b0;
        cyc();
        e_rv = 1'b0;
    endtask

    task automatic do_write(input logic [A-1:0] addr, input logic [W-1:0] base,
                            input logic [W-1:0] step, input int gap, input bit noise);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = addr;
        for (int k = 0; k < N; k++) req_wdata[k*W +: W] = base + W'(k) * step;
        cyc();
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        e_rv = 1'b0; e_ready = 1'b0; e_op = 2'b11;
        e_addr = addr; e_addr_chk = 1'b1;
        e_wd_chk = 1'b1; e_wdata = base;
        cyc();
        e_in_send = 1'b1;
        for (int k = 0; k < N; k++) begin
            e_wdata = base + W'(k) * step;
            mc_rd_valid = noise && (k == 5);
            mc_rdata    = mc_rd_valid ? 32'hDEAD_BEEF : '0;
            cyc();
        end
        e_in_send   = 1'b0;
        mc_rd_valid = 1'b0;
        mc_rdata    = '0;
        e_wd_chk    = 1'b0;
        for (int g = 0; g < gap; g++) begin
            mc_tx_done = (g == gap - 1);
            cyc();
        end
        mc_tx_done = 1'b0;
        e_op = 2'b00; e_rv = 1'b1; e_rwe = 1'b1; e_ready = 1'b1; e_addr_chk = 1'b0;
    endtask

    task automatic do_read(input logic [A-1:0] addr, input int stall, input int nw,
                           input logic [W-1:0] base, input logic [W-1:0] step);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = addr;
        cyc();
        req_valid = 1'b0;
        req_addr  = '0;
        e_rv = 1'b0; e_ready = 1'b0; e_op = 2'b01;
        e_addr = addr; e_addr_chk = 1'b1; e_wd_chk = 1'b0;
        for (int s = 0; s < stall; s++) cyc();
        for (int k = 0; k < nw; k++) begin
            mc_rd_valid = 1'b1;
            mc_rdata    = base + W'(k) * step;
            mc_tx_done  = (k == nw - 1);
            cyc();
        end
        mc_rd_valid = 1'b0;
        mc_tx_done  = 1'b0;
        mc_rdata    = '0;
        e_op = 2'b00; e_rv = 1'b1; e_rwe = 1'b0; e_ready = 1'b1; e_addr_chk = 1'b0;
        for (int k = 0; k < N; k++) begin
            e_ok[k] = (k < nw);
            if (k < nw) e_line[k] = base + W'(k) * step;
        end
        if (nw != N) e_perr = SHORT_PERR;
    endtask

    task automatic set_reset_exp();
        e_ready = 1'b0; e_op = 2'b00; e_rv = 1'b0; e_rwe = 1'b0; e_perr = 1'b0;
        e_addr = '0; e_addr_chk = 1'b1;
        e_wdata = '0; e_wd_chk = 1'b1;
        for (int k = 0; k < N; k++) begin
            e_line[k] = '0;
            e_ok[k]   = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mc_rdata = '0; mc_rd_valid = 1'b0; mc_ready = 1'b0; mc_tx_done = 1'b0;
        set_reset_exp();
        cyc();
        chk_en = 1'b1;
        cyc();

        rst_n     = 1'b1;
        req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mc_tx_done  = (i == 3);
            mc_rd_valid = (i == 4);
            mc_rdata    = (i == 4) ? 32'h5555_AAAA : '0;
            cyc();
        end
        mc_ready = 1'b1; req_valid = 1'b0; mc_tx_done = 1'b0; mc_rd_valid = 1'b0; mc_rdata = '0;
        cyc();
        e_ready = 1'b1; e_wd_chk = 1'b0; e_addr_chk = 1'b0;
        cyc();

        q_wd.delete();
        do_write(64'h1234_5678_9ABC_DEC0, 32'hA000_0000, 32'h1, 3, 1'b1);
        chk("pin_send_cycles", CL'(q_wd.size()), CL'(16));
        chk("pin_send_word0", CL'(q_wd[0]), CL'(32'hA000_0000));
        chk("pin_send_word15", CL'(q_wd[15]), CL'(32'hA000_000F));
        mc_tx_done = 1'b1;
        idle_cyc();
        mc_tx_done = 1'b0;
        idle_cyc();

        do_read(64'h0000_0000_0000_0100, 5, 16, 32'h1000, 32'h1);
        chk("pin_rd_word0", CL'(resp_rdata[31:0]), CL'(32'h0000_1000));
        chk("pin_rd_word15", CL'(resp_rdata[511:480]), CL'(32'h0000_100F));
        idle_cyc();
        chk("pin_resp_count", CL'(n_rv), CL'(2));

        do_write(64'h0000_0000_0000_0200, 32'hB000_0000, 32'h11, 1, 1'b0);
        do_read(64'h0000_0000_0000_0300, 0, 16, 32'h2000, 32'h3);
        chk("pin_b2b_word15", CL'(resp_rdata[511:480]), CL'(32'h0000_202D));
        idle_cyc();
        idle_cyc();
        chk("pin_b2b_resp_count", CL'(n_rv), CL'(4));

        do_read(64'h0000_0000_0000_0400, 2, 15, 32'h5000, 32'h1);
        idle_cyc();
        idle_cyc();
        idle_cyc();

        rv_before = n_rv;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 64'h0000_0000_0000_4000;
        for (int k = 0; k < N; k++) req_wdata[k*W +: W] = 32'hC000_0000 + W'(k);
        cyc();
        req_valid = 1'b0;
        e_rv = 1'b0; e_ready = 1'b0; e_op = 2'b11;
        e_addr = 64'h0000_0000_0000_4000; e_addr_chk = 1'b1;
        e_wd_chk = 1'b1; e_wdata = 32'hC000_0000;
        cyc();
        for (int k = 0; k < 7; k++) begin
            e_wdata = 32'hC000_0000 + W'(k);
            cyc();
        end
        e_wdata = 32'hC000_0007;
        #1;
        set_reset_exp();
        rst_n    = 1'b0;
        mc_ready = 1'b0;
        #1;
        chk("async_mc_op", CL'(mc_op), CL'(2'b00));
        chk("async_req_ready", CL'(req_ready), CL'(1'b0));
        chk("async_resp_valid", CL'(resp_valid), CL'(1'b0));
        chk("async_resp_we", CL'(resp_we), CL'(1'b0));
        chk("async_resp_rdata", resp_rdata, '0);
        chk("async_mc_addr", CL'(mc_addr), '0);
        chk("async_mc_wdata", CL'(mc_wdata), '0);
        chk("async_proto_err", CL'(proto_err), '0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        cyc();
        cyc();
        mc_ready = 1'b1;
        cyc();
        e_ready = 1'b1; e_wd_chk = 1'b0; e_addr_chk = 1'b0;
        cyc();
        chk("no_resp_after_abort", CL'(n_rv), CL'(rv_before));

        do_read(64'h0000_0000_0000_0500, 2, 16, 32'h3000, 32'h1);
        idle_cyc();
        idle_cyc();
        chk("pin_final_rd_word7", CL'(resp_rdata[255:224]), CL'(32'h0000_3007));

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_client.md
MEM_CLIENT -- requirements
Module: mem_client

Interface
REQ-001 Parameter WORD_SIZE, default 32, width of one word on the word bus.
REQ-002 Parameter CL_SIZE_WIDTH, default 512, cache-line width in bits; N = CL_SIZE_WIDTH/WORD_SIZE words per line.
REQ-003 Parameter ADDR_BITCOUNT, default 64, address width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid / req_ready  input / output  1 / 1  upstream line request handshake; accepted when both high on a clock edge.
REQ-007 req_we  input  1  1 = line write, 0 = line read.
REQ-008 req_addr  input  ADDR_BITCOUNT  line address.
REQ-009 req_wdata  input  CL_SIZE_WIDTH  line to write; word 0 at bits [WORD_SIZE-1:0].
REQ-010 resp_valid  output  1  one-cycle completion pulse for reads and writes.
REQ-011 resp_we  output  1  copy of req_we for the completing request.
REQ-012 resp_rdata  output  CL_SIZE_WIDTH  assembled read line, valid with resp_valid.
REQ-013 mc_op  output  2  controller opcode: 00 idle, 01 read, 11 write.
REQ-014 mc_addr  output  ADDR_BITCOUNT  registered req_addr, held stable for the whole transaction.
REQ-015 mc_wdata  output  WORD_SIZE  word bus toward the controller.
REQ-016 mc_rdata / mc_rd_valid  input / input  WORD_SIZE / 1  word bus from the controller and its valid strobe.
REQ-017 mc_ready / mc_tx_done  input / input  1 / 1  controller initialised; transaction complete.
REQ-018 proto_err  output  1  sticky protocol error flag (see Configuration).

Function
REQ-019 States: INIT, IDLE, WR_ISSUE, WR_SEND, WR_WAIT, RD_WAIT.
REQ-020 INIT -> IDLE on the first cycle mc_ready = 1; req_ready = 0 in INIT.
REQ-021 req_ready = 1 only in IDLE; on acceptance, the block registers addr, we and wdata, sets word index to 0, and drives mc_op to 11 (write) or 01 (read) from the next cycle.
REQ-022 Write: WR_ISSUE lasts exactly 1 cycle with mc_op = 11 and mc_wdata = word 0; WR_SEND then lasts exactly N cycles, driving word k in WR_SEND cycle k (k = 0..N-1, LSB word first); WR_WAIT follows.
REQ-023 WR_WAIT: mc_op held 11 until mc_tx_done = 1; that edge sets mc_op = 00, pulses resp_valid = 1 with resp_we = 1 in the following cycle, and enters IDLE.
REQ-024 Read: RD_WAIT holds mc_op = 01; each cycle with mc_rd_valid = 1 stores mc_rdata into word slot [index] and increments the index, wrapping modulo N.
REQ-025 RD_WAIT: the mc_tx_done cycle also carries the last word; that word is stored; at that edge mc_op = 00, resp_rdata is loaded with the full line, resp_valid pulses next cycle, and the state enters IDLE.
REQ-026 mc_op returns to 00 in the cycle immediately after mc_tx_done so the controller never re-issues; a new request accepted in that IDLE cycle is legal.
REQ-027 mc_tx_done or mc_rd_valid in INIT, IDLE, WR_ISSUE or WR_SEND is ignored; it has no effect on state or data.
REQ-028 resp_rdata holds its value until the next read completes.

Reset
REQ-029 On rst_n low, the block enters INIT immediately; mc_op = 00, req_ready = 0, resp_valid = 0, resp_we = 0, resp_rdata = 0, mc_addr = 0, mc_wdata = 0, index = 0, proto_err = 0.
REQ-030 Reset mid-transaction abandons it without a response; after deassertion, the block waits for mc_ready again.

Configuration
REQ-031 Macro MEM_CLIENT_WORD_CHECK_EN: when defined, proto_err is set and stays set until reset if a read's mc_tx_done arrives with a stored-word count other than N, or if a write's mc_tx_done arrives outside WR_WAIT.
REQ-032 When MEM_CLIENT_WORD_CHECK_EN is not defined, proto_err is tied to 0 and no checking logic exists.

Verification (WORD_SIZE=32, CL_SIZE_WIDTH=512, N=16)
REQ-033 mc_ready held 0 for 10 cycles, req_valid=1 -> req_ready stays 0, mc_op=00 until mc_ready=1.
REQ-034 Write of req_wdata word k = 0xA000_0000+k, mc_tx_done 3 cycles after the last word -> mc_wdata sequence 0xA0000000..0xA000000F on WR_SEND cycles 0..15, one resp_valid with resp_we=1, mc_op=00 the cycle after mc_tx_done.
REQ-035 Read: 5-cycle stall, then 16 rd_valid words 0x1000+k, tx_done on the 16th -> resp_rdata word k = 0x1000+k, resp_valid exactly once.
REQ-036 Back-to-back: a read is accepted in the IDLE cycle right after a write completes -> mc_op goes 11 -> 00 -> 01 with no duplicate transaction.
REQ-037 rst_n asserted in WR_SEND cycle 7 -> all outputs take reset values asynchronously; no resp_valid follows.
REQ-038 With MEM_CLIENT_WORD_CHECK_EN, tx_done after 15 read words -> proto_err=1, held until reset; without the macro -> proto_err=0.
